// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a two-entry skid buffer, a flush and a stall counter.
// in_ready comes from registers only, so no combinational ready path runs back upstream.
module pipe_skid_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  cnt;

  logic accept;
  logic pop;
  logic stall;

  assign in_ready  = !skid_v;
  assign accept    = in_valid & in_ready;
  assign pop       = main_v & out_ready;
  assign stall     = main_v & ~out_ready;

  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_data;
  assign stall_cnt = cnt;

  // Flush wins; payload registers keep their contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_v    <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      unique case (1'b1)
        !main_v: begin
          if (accept) begin
            main_v    <= 1'b1;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        main_v && !skid_v: begin
          if (accept && !pop) begin
            skid_v    <= 1'b1;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (accept) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (pop) begin
            main_v <= 1'b0;
          end
        end
        main_v && skid_v: begin
          if (pop) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_v    <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (stall && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: vector table plus reset,
// async-reset and counter-saturation sequences.
module tb_pipe_skid_reg;

  logic         clock;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_ctrl;
  logic [100:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_ctrl;
  logic [100:0] out_data;
  logic [15:0]  stall_cnt;

  logic         s_reset;
  logic         s_flush;
  logic         s_in_valid;
  logic         s_in_ready;
  logic [5:0]   s_in_ctrl;
  logic [7:0]   s_in_data;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [5:0]   s_out_ctrl;
  logic [7:0]   s_out_data;
  logic [3:0]   s_stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_skid_reg dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(8), .CTRL_W(6), .CNT_W(4)) sat (
    .clock     (clock),
    .reset     (s_reset),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_ctrl   (s_in_ctrl),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_ctrl  (s_out_ctrl),
    .out_data  (s_out_data),
    .stall_cnt (s_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         iv;
    logic         ordy;
    logic         fl;
    logic [5:0]   ctrl;
    logic [100:0] data;
    logic         ev;
    logic         er;
    logic [5:0]   ectrl;
    logic [100:0] edata;
    logic [15:0]  ecnt;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(
    input logic iv, input logic ordy, input logic fl,
    input logic [5:0] ctrl, input logic [100:0] data,
    input logic ev, input logic er,
    input logic [5:0] ectrl, input logic [100:0] edata,
    input logic [15:0] ecnt);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl;
    v.ctrl = ctrl; v.data = data;
    v.ev = ev; v.er = er;
    v.ectrl = ectrl; v.edata = edata; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [100:0] p;

  initial begin
    p = {32'd1234, 32'd12345, 32'd4321, 5'd31};
    reset = 1'b1; s_reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_in_ctrl = '0; s_in_data = '0;

    vt[0]  = mk(1,1,0, 6'h3f, p,     1,1, 6'h3f, p,     0);
    vt[1]  = mk(0,1,0, 6'h00, 0,     0,1, 6'h00, p,     0);
    vt[2]  = mk(0,1,0, 6'h00, 0,     0,1, 6'h00, p,     0);
    vt[3]  = mk(1,1,0, 6'h01, 1,     1,1, 6'h01, 1,     0);
    vt[4]  = mk(1,0,0, 6'h02, 2,     1,0, 6'h01, 1,     1);
    vt[5]  = mk(1,0,0, 6'h03, 3,     1,0, 6'h01, 1,     2);
    vt[6]  = mk(1,0,0, 6'h03, 3,     1,0, 6'h01, 1,     3);
    vt[7]  = mk(1,1,0, 6'h03, 3,     1,1, 6'h02, 2,     3);
    vt[8]  = mk(1,1,0, 6'h03, 3,     1,1, 6'h03, 3,     3);
    vt[9]  = mk(1,1,0, 6'h04, 4,     1,1, 6'h04, 4,     3);
    vt[10] = mk(0,1,0, 6'h00, 0,     0,1, 6'h00, 4,     3);
    vt[11] = mk(1,0,0, 6'h0a, 'ha,   1,1, 6'h0a, 'ha,   3);
    vt[12] = mk(1,0,0, 6'h0b, 'hb,   1,0, 6'h0a, 'ha,   4);
    vt[13] = mk(1,0,1, 6'h0c, 'hc,   0,1, 6'h00, 'ha,   5);
    vt[14] = mk(0,1,0, 6'h00, 0,     0,1, 6'h00, 'ha,   5);
    vt[15] = mk(1,1,0, 6'h0d, 'hd,   1,1, 6'h0d, 'hd,   5);
    vt[16] = mk(1,1,1, 6'h0e, 'he,   0,1, 6'h00, 'hd,   5);
    vt[17] = mk(0,1,0, 6'h00, 0,     0,1, 6'h00, 'hd,   5);

    step();
    step();
    reset = 1'b0; s_reset = 1'b0;
    step();
    check("rst_valid", 128'(out_valid), 128'(1'b0));
    check("rst_ctrl",  128'(out_ctrl),  128'(6'h0));
    check("rst_data",  128'(out_data),  128'(101'h0));
    check("rst_ready", 128'(in_ready),  128'(1'b1));
    check("rst_cnt",   128'(stall_cnt), 128'(16'h0));

    for (int i = 0; i < 18; i++) begin
      in_valid  = vt[i].iv;
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      in_ctrl   = vt[i].ctrl;
      in_data   = vt[i].data;
      step();
      check($sformatf("v%0d_valid", i), 128'(out_valid), 128'(vt[i].ev));
      check($sformatf("v%0d_ready", i), 128'(in_ready),  128'(vt[i].er));
      check($sformatf("v%0d_ctrl", i),  128'(out_ctrl),  128'(vt[i].ectrl));
      check($sformatf("v%0d_data", i),  128'(out_data),  128'(vt[i].edata));
      check($sformatf("v%0d_cnt", i),   128'(stall_cnt), 128'(vt[i].ecnt));
    end
    flush = 1'b0;

    // fill to FULL, then reset between edges
    in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 6'h11; in_data = 'h11;
    step();
    in_ctrl = 6'h12; in_data = 'h12;
    step();
    check("full_ready", 128'(in_ready),  128'(1'b0));
    check("full_cnt",   128'(stall_cnt), 128'(16'd6));
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid), 128'(1'b0));
    check("arst_ctrl",  128'(out_ctrl),  128'(6'h0));
    check("arst_data",  128'(out_data),  128'(101'h0));
    check("arst_ready", 128'(in_ready),  128'(1'b1));
    check("arst_cnt",   128'(stall_cnt), 128'(16'h0));
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = 6'h13; in_data = 'h13;
    step();
    check("post_valid", 128'(out_valid), 128'(1'b1));
    check("post_ctrl",  128'(out_ctrl),  128'(6'h13));
    check("post_data",  128'(out_data),  128'(101'h13));
    in_valid = 1'b0;
    step();
    check("post_drain", 128'(out_valid), 128'(1'b0));

    // 4-bit stall counter saturation
    s_in_valid = 1'b1; s_out_ready = 1'b0;
    s_in_ctrl = 6'h21; s_in_data = 8'h5a;
    step();
    s_in_valid = 1'b0;
    check("sat_c0", 128'(s_stall_cnt), 128'(4'd0));
    repeat (14) step();
    check("sat_c14", 128'(s_stall_cnt), 128'(4'd14));
    repeat (6) step();
    check("sat_c15",   128'(s_stall_cnt), 128'(4'd15));
    check("sat_valid", 128'(s_out_valid), 128'(1'b1));
    check("sat_data",  128'(s_out_data),  128'(8'h5a));
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    check("sat_fl_valid", 128'(s_out_valid), 128'(1'b0));
    step();
    check("sat_fl_cnt", 128'(s_stall_cnt), 128'(4'd15));
    s_reset = 1'b1;
    #1;
    check("sat_rst_cnt", 128'(s_stall_cnt), 128'(4'd0));
    s_reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
